accel_seq: RTL and testbench

ACCEL_SEQ -- requirements
Module: accel_seq

---
 rtl/accel_seq.sv | 208 ++++++++++++++++++++
 tb/tb_accel_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_seq.sv
`default_nettype none
// accel_seq: runs one job at a time, reading up to MAX_SRC operands, issuing the accelerator op
// and the result write over an arbitrated bus, then posting a completion entry.
module accel_seq #(
  parameter int         ADDRW    = 24,
  parameter logic [1:0] ACCEL_ID = 2'b10,
  parameter int         MAX_SRC  = 3,
  parameter int         TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [(MAX_SRC+1)*ADDRW+2:0] req_data,
  output logic                         ready_req_out,
  output logic                         arb_req,
  input  logic                         arb_grant,
  input  logic [2:0]                   ack_in,
  output logic [ADDRW+7:0]             data_out,
  input  logic                         compq_ready_in,
  output logic                         valid_compq_out,
  output logic [ADDRW-1:0]             compq_data_out,
  output logic                         compq_err_out
);

  localparam int            W          = (MAX_SRC + 1) * ADDRW;
  localparam logic [1:0]    MEM_ID     = 2'b00;
  localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0]    MAX_NSRC   = 2'(MAX_SRC);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_RD = 3'd1,
    WAIT_RD  = 3'd2,
    ISSUE_OP = 3'd3,
    WAIT_OP  = 3'd4,
    ISSUE_WR = 3'd5,
    WAIT_WR  = 3'd6,
    COMPLETE = 3'd7
  } state_t;

  state_t        state, state_nxt;
  logic [W+2:0]  job;
  logic          load_job;
  logic [1:0]    src_idx, src_idx_nxt;
  logic [TW-1:0] timer, timer_nxt, timer_inc;
  logic          err, err_nxt;

  logic [1:0]       job_nsrc;
  logic             job_mode;
  logic [ADDRW-1:0] job_dest;
  logic [ADDRW-1:0] src_sel;
  logic [1:0]       req_nsrc;
  logic             req_ok;
  logic [ADDRW+7:0] rd_cmd, op_cmd, wr_cmd;
  logic             ack_mem, ack_acc, expire;

  assign job_nsrc = job[W+2:W+1];
  assign job_mode = job[W];
  assign job_dest = job[ADDRW-1:0];
  assign req_nsrc = req_data[W+2:W+1];
  assign req_ok   = (req_nsrc != 2'd0) && (req_nsrc <= MAX_NSRC);

  // src0 sits in the top slot, so operand i lives (MAX_SRC - i) slots above dest.
  always_comb begin
    src_sel = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (src_idx == 2'(i)) src_sel = job[(MAX_SRC-i)*ADDRW +: ADDRW];
    end
  end

  assign rd_cmd = {src_sel, 2'b00, ACCEL_ID, MEM_ID, (src_idx == 2'd0) ? 2'b00 : 2'b01};
  assign op_cmd = {{ADDRW{1'b0}}, job_mode, 1'b0, ACCEL_ID, 4'b0011};
  assign wr_cmd = {job_dest, 2'b00, MEM_ID, ACCEL_ID, 2'b10};

  assign ack_mem   = (ack_in == {1'b1, MEM_ID});
  assign ack_acc   = (ack_in == {1'b1, ACCEL_ID});
  assign expire    = TIMEOUT_EN && (timer == TIMER_LAST);
  assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);

  always_comb begin
    state_nxt       = state;
    src_idx_nxt     = src_idx;
    timer_nxt       = timer;
    err_nxt         = err;
    load_job        = 1'b0;
    ready_req_out   = 1'b0;
    arb_req         = 1'b0;
    data_out        = '0;
    valid_compq_out = 1'b0;
    compq_data_out  = '0;
    compq_err_out   = 1'b0;

    case (state)
      IDLE: begin
        ready_req_out = 1'b1;
        if (req_valid) begin
          load_job    = 1'b1;
          src_idx_nxt = '0;
          timer_nxt   = '0;
          if (req_ok) begin
            state_nxt = ISSUE_RD;
            err_nxt   = 1'b0;
          end else begin
            state_nxt = COMPLETE;
            err_nxt   = 1'b1;
          end
        end
      end

      ISSUE_RD: begin
        arb_req  = 1'b1;
        data_out = rd_cmd;
        if (arb_grant) begin
          state_nxt = WAIT_RD;
          timer_nxt = '0;
        end
      end

      WAIT_RD: begin
        data_out = rd_cmd;
        if (ack_mem) begin
          if (src_idx == job_nsrc - 2'd1) begin
            state_nxt = ISSUE_OP;
          end else begin
            src_idx_nxt = src_idx + 2'd1;
            state_nxt   = ISSUE_RD;
          end
        end else if (expire) begin
          state_nxt = COMPLETE;
          err_nxt   = 1'b1;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      ISSUE_OP: begin
        arb_req  = 1'b1;
        data_out = op_cmd;
        if (arb_grant) begin
          state_nxt = WAIT_OP;
          timer_nxt = '0;
        end
      end

      WAIT_OP: begin
        data_out = op_cmd;
        if (ack_acc) begin
          state_nxt = ISSUE_WR;
        end else if (expire) begin
          state_nxt = COMPLETE;
          err_nxt   = 1'b1;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      ISSUE_WR: begin
        arb_req  = 1'b1;
        data_out = wr_cmd;
        if (arb_grant) begin
          state_nxt = WAIT_WR;
          timer_nxt = '0;
        end
      end

      WAIT_WR: begin
        data_out = wr_cmd;
        if (ack_mem) begin
          state_nxt = COMPLETE;
        end else if (expire) begin
          state_nxt = COMPLETE;
          err_nxt   = 1'b1;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      COMPLETE: begin
        valid_compq_out = 1'b1;
        compq_data_out  = job_dest;
        compq_err_out   = err;
        if (compq_ready_in) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      job     <= '0;
      src_idx <= '0;
      timer   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      if (load_job) job <= req_data;
      src_idx <= src_idx_nxt;
      timer   <= timer_nxt;
      err     <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_seq.sv
`default_nettype none
// Randomized jobs for accel_seq; a transaction-level model fills scoreboard queues that a
// negedge monitor drains whenever the DUT hands over a bus command or a completion entry.
module tb_accel_seq;

  localparam int         ADDRW    = 24;
  localparam int         MAX_SRC  = 3;
  localparam int         TIMEOUT  = 8;
  localparam logic [1:0] ACCEL_ID = 2'b10;
  localparam int         W        = (MAX_SRC + 1) * ADDRW;
  localparam int         RW       = W + 3;
  localparam int         ACC      = 2;
  localparam int         MEM      = 0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [RW-1:0]    req_data = '0;
  logic             ready_req_out;
  logic             arb_req;
  logic             arb_grant = 1'b0;
  logic [2:0]       ack_in = 3'b000;
  logic [ADDRW+7:0] data_out;
  logic             compq_ready_in = 1'b0;
  logic             valid_compq_out;
  logic [ADDRW-1:0] compq_data_out;
  logic             compq_err_out;

  accel_seq #(
    .ADDRW(ADDRW), .ACCEL_ID(ACCEL_ID), .MAX_SRC(MAX_SRC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .ready_req_out(ready_req_out), .arb_req(arb_req), .arb_grant(arb_grant),
    .ack_in(ack_in), .data_out(data_out), .compq_ready_in(compq_ready_in),
    .valid_compq_out(valid_compq_out), .compq_data_out(compq_data_out),
    .compq_err_out(compq_err_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cmd[$];
  logic [24:0] exp_comp[$];
  logic [31:0] exp_list[5];
  int          n_tr;
  logic        exp_err;
  int          gdel[5];
  int          adel[5];
  int          fixed_noise = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] noise(input logic [2:0] match);
    logic [2:0] v;
    if (fixed_noise >= 0 && 3'(fixed_noise) != match) return 3'(fixed_noise);
    do v = 3'($urandom_range(0, 7)); while (v == match);
    return v;
  endfunction

  // Expected bus traffic of one job: nsrc reads, op, write; a silent transaction ends the job in error.
  task automatic model(input int nsrc, input int mode, input logic [23:0] s0, s1, s2, dest,
                       input int drop_t);
    logic [23:0] src[3];
    src[0] = s0; src[1] = s1; src[2] = s2;
    n_tr = 0;
    exp_err = (nsrc < 1 || nsrc > MAX_SRC);
    if (!exp_err) begin
      for (int i = 0; i < nsrc; i++) begin
        exp_list[i] = 32'(src[i]) * 256 + ACC * 16 + MEM * 4 + ((i == 0) ? 0 : 1);
      end
      exp_list[nsrc]     = mode * 128 + ACC * 16 + 3;
      exp_list[nsrc + 1] = 32'(dest) * 256 + MEM * 16 + ACC * 4 + 2;
      n_tr = nsrc + 2;
      if (drop_t >= 0 && drop_t < n_tr) begin
        n_tr    = drop_t + 1;
        exp_err = 1'b1;
      end
    end
    for (int i = 0; i < n_tr; i++) exp_cmd.push_back(exp_list[i]);
    exp_comp.push_back({exp_err, dest});
  endtask

  always @(negedge clk) begin
    if (rst_n && arb_req && arb_grant) begin
      if (exp_cmd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cmd: got %0h expected none", data_out);
      end else begin
        chk("bus_cmd", data_out, exp_cmd.pop_front());
      end
    end
    if (rst_n && valid_compq_out && compq_ready_in) begin
      if (exp_comp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_compq: got %0h expected none", {compq_err_out, compq_data_out});
      end else begin
        chk("compq_entry", {compq_err_out, compq_data_out}, exp_comp.pop_front());
      end
    end
  end

  task automatic clr_delays();
    for (int t = 0; t < 5; t++) begin
      gdel[t] = 0;
      adel[t] = 0;
    end
    fixed_noise = -1;
  endtask

  task automatic run_job(input int nsrc, input int mode, input logic [23:0] s0, s1, s2, dest,
                         input int drop_t, input int cr_del);
    logic [2:0] match;
    int n, ad;
    model(nsrc, mode, s0, s1, s2, dest, drop_t);
    chk("idle_ready", ready_req_out, 1);
    req_data  = {2'(nsrc), 1'(mode), s0, s1, s2, dest};
    req_valid = 1'b1;
    tick();
    req_valid = 1'($urandom);
    req_data  = RW'({$urandom, $urandom, $urandom, $urandom});
    if (nsrc == 0) chk("complete_next", {valid_compq_out, arb_req}, 2'b10);
    for (int t = 0; t < n_tr; t++) begin
      match = (t == nsrc) ? {1'b1, ACCEL_ID} : 3'b100;
      n = 0;
      while (!arb_req && n < 40) begin
        ack_in = noise(match);
        tick();
        n++;
      end
      chk("arb_req_seen", arb_req, 1);
      if (!arb_req) break;
      for (int k = 0; k < gdel[t]; k++) begin
        ack_in = noise(match);
        tick();
        chk("issue_hold", {arb_req, valid_compq_out, data_out}, {1'b1, 1'b0, exp_list[t]});
      end
      arb_grant = 1'b1;
      ack_in    = noise(match);
      tick();
      arb_grant = 1'b0;
      ad = (t == drop_t) ? TIMEOUT - 1 : adel[t];
      for (int k = 0; k < ad; k++) begin
        ack_in = noise(match);
        tick();
        chk("wait_hold", {arb_req, valid_compq_out, data_out}, {1'b0, 1'b0, exp_list[t]});
      end
      if (t == drop_t) begin
        ack_in = noise(match);
        tick();
        chk("timeout_complete", {valid_compq_out, compq_err_out}, 2'b11);
      end else begin
        ack_in = match;
        tick();
      end
      ack_in = 3'b000;
    end
    req_valid = 1'b0;
    ack_in    = 3'b000;
    n = 0;
    while (!valid_compq_out && n < 40) begin
      tick();
      n++;
    end
    for (int k = 0; k < cr_del; k++) begin
      chk("compq_hold", {valid_compq_out, arb_req, compq_err_out, compq_data_out},
          {2'b10, exp_err, dest});
      tick();
    end
    chk("compq_present", {valid_compq_out, compq_err_out, compq_data_out}, {1'b1, exp_err, dest});
    compq_ready_in = 1'b1;
    tick();
    compq_ready_in = 1'b0;
    chk("back_to_idle", {ready_req_out, valid_compq_out}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, ns, drop;
    #3;
    chk("reset_state", {ready_req_out, arb_req, valid_compq_out, compq_err_out, data_out,
                        compq_data_out}, {1'b1, 59'b0});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    clr_delays();
    run_job(2, 1, 24'h000100, 24'h000200, 24'h0, 24'h000300, -1, 0);

    clr_delays();
    adel[2] = 7;
    run_job(3, 0, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D, -1, 1);

    clr_delays();
    run_job(1, 1, 24'h123456, 24'h0, 24'h0, 24'h654321, 1, 0);

    clr_delays();
    adel[1] = 7;
    run_job(1, 0, 24'h111111, 24'h0, 24'h0, 24'h222222, -1, 0);

    clr_delays();
    run_job(0, 1, 24'hFFFFFF, 24'h0, 24'h0, 24'hABCDEF, -1, 5);

    clr_delays();
    fixed_noise = 6;
    gdel[2] = 20;
    adel[0] = 3;
    adel[1] = 4;
    run_job(2, 1, 24'h00AA00, 24'h00BB00, 24'h0, 24'h00CC00, -1, 0);

    // Abort mid-read with an asynchronous reset, then run a fresh job.
    clr_delays();
    model(2, 0, 24'h010101, 24'h020202, 24'h0, 24'h030303, -1);
    req_data  = {2'd2, 1'b0, 24'h010101, 24'h020202, 24'h0, 24'h030303};
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!arb_req && n < 40) begin
      tick();
      n++;
    end
    arb_grant = 1'b1;
    tick();
    arb_grant = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", {ready_req_out, arb_req, valid_compq_out, compq_err_out, data_out,
                        compq_data_out}, {1'b1, 59'b0});
    exp_cmd.delete();
    exp_comp.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_job(3, 1, 24'h445566, 24'h778899, 24'hAABBCC, 24'hDDEEFF, -1, 0);

    for (int j = 0; j < 24; j++) begin
      clr_delays();
      for (int t = 0; t < 5; t++) begin
        gdel[t] = $urandom_range(0, 3);
        adel[t] = $urandom_range(0, TIMEOUT - 1);
      end
      ns   = $urandom_range(0, 3);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ns + 1) : -1;
      run_job(ns, $urandom_range(0, 1), 24'($urandom), 24'($urandom), 24'($urandom),
              24'($urandom), drop, $urandom_range(0, 3));
    end

    tick();
    chk("sb_empty", exp_cmd.size() + exp_comp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
